// File: rtl/exu_trap_ctrl_pkg.sv
// Shared definitions for the trap/return sequencer: FSM states, interrupt
// cause codes and the mtvec vectored-mode encoding.
package exu_trap_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_TRAP  = 2'd2,
      ST_FLUSH = 2'd3
   } state_e;

   localparam logic [3:0] CODE_MEI = 4'd11;
   localparam logic [3:0] CODE_MSI = 4'd3;
   localparam logic [3:0] CODE_MTI = 4'd7;

   localparam logic [1:0] MTVEC_MODE_VEC = 2'b01;

endpackage

// File: rtl/exu_trap_ctrl_if.sv
// Commit, interrupt, CSR and IFU-redirect signals of the trap sequencer.
// master = trap sequencer, slave = surrounding core.
interface exu_trap_ctrl_if #(
   parameter int PC_W = 32
);
   logic            cmt_valid;
   logic [PC_W-1:0] cmt_pc;
   logic            cmt_excp;
   logic [3:0]      cmt_excp_code;
   logic            cmt_mret;
   logic            cmt_stall;
   logic            cmt_retire;
   logic            lsu_busy;
   logic            ext_ip;
   logic            tmr_ip;
   logic            sft_ip;
   logic [PC_W-1:0] csr_mie;
   logic            csr_mstatus_mie;
   logic [PC_W-1:0] csr_mtvec;
   logic [PC_W-1:0] csr_mepc;
   logic            int_ena;
   logic [PC_W-1:0] i_mcause;
   logic [PC_W-1:0] epc_pc;
   logic            mret_ena;
   logic            flush_req;
   logic [PC_W-1:0] flush_pc;
   logic            flush_ack;
   logic            drain_tmo;

   modport master (
      input  cmt_valid, cmt_pc, cmt_excp, cmt_excp_code, cmt_mret,
      input  lsu_busy, ext_ip, tmr_ip, sft_ip,
      input  csr_mie, csr_mstatus_mie, csr_mtvec, csr_mepc, flush_ack,
      output cmt_stall, cmt_retire, int_ena, i_mcause, epc_pc,
      output mret_ena, flush_req, flush_pc, drain_tmo
   );

   modport slave (
      output cmt_valid, cmt_pc, cmt_excp, cmt_excp_code, cmt_mret,
      output lsu_busy, ext_ip, tmr_ip, sft_ip,
      output csr_mie, csr_mstatus_mie, csr_mtvec, csr_mepc, flush_ack,
      input  cmt_stall, cmt_retire, int_ena, i_mcause, epc_pc,
      input  mret_ena, flush_req, flush_pc, drain_tmo
   );

endinterface

// File: rtl/exu_trap_ctrl_prio.sv
// Combinational machine-interrupt priority encoder: MEI > MSI > MTI.
// Inputs are already masked by mie and mstatus.MIE.
module exu_trap_ctrl_prio
   import exu_trap_ctrl_pkg::*;
(
   input  logic       ext_pend,
   input  logic       sft_pend,
   input  logic       tmr_pend,
   output logic       valid,
   output logic [3:0] code
);

   // NOTE: every output gets a default before the if-chain so no path leaves it unassigned (no latch).
   always_comb begin
      valid = 1'b1;
      code  = CODE_MEI;
      if (ext_pend) begin
         code = CODE_MEI;
      end else if (sft_pend) begin
         code = CODE_MSI;
      end else if (tmr_pend) begin
         code = CODE_MTI;
      end else begin
         valid = 1'b0;
         code  = '0;
      end
   end

endmodule

// File: rtl/exu_trap_ctrl.sv
// Trap/return sequencer at the EXU commit point: LSU drain, trap/mret strobes,
// IFU flush/redirect handshake and instret strobe. Vectored interrupt entry is
// enabled by defining EXU_TRAP_VECTORED_EN.
module exu_trap_ctrl
   import exu_trap_ctrl_pkg::*;
#(
   parameter int PC_W      = 32,
   parameter int DRAIN_TMO = 255,
   parameter int TMO_W     = 8
) (
   input logic             clk,
   input logic             rst_n,
   exu_trap_ctrl_if.master bus
);

   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(DRAIN_TMO);
`ifdef EXU_TRAP_VECTORED_EN
   localparam bit VEC_EN = 1'b1;
`else
   localparam bit VEC_EN = 1'b0;
`endif

   state_e           state, state_nxt;
   logic [TMO_W-1:0] drain_cnt, drain_cnt_nxt, drain_cnt_inc;
   logic             cause_irq, cause_irq_nxt;
   logic [3:0]       cause_code, cause_code_nxt;
   logic [PC_W-1:0]  epc, epc_nxt;
   logic [PC_W-1:0]  target, target_nxt;
   logic             irq_valid;
   logic [3:0]       irq_code;
   logic             retire, mret_strobe, trap_strobe, tmo_strobe;
   logic             unused_bits;

   exu_trap_ctrl_prio u_prio (
      .ext_pend (bus.csr_mstatus_mie & bus.ext_ip & bus.csr_mie[11]),
      .sft_pend (bus.csr_mstatus_mie & bus.sft_ip & bus.csr_mie[3]),
      .tmr_pend (bus.csr_mstatus_mie & bus.tmr_ip & bus.csr_mie[7]),
      .valid    (irq_valid),
      .code     (irq_code)
   );

   // Vectored offset applies only to interrupts with mtvec in vectored mode.
   function automatic logic [PC_W-1:0] trap_target(input logic [PC_W-1:0] mtvec,
                                                   input logic            irq,
                                                   input logic [3:0]      code);
      logic [PC_W-1:0] base;
      base = {mtvec[PC_W-1:2], 2'b00};
      if (VEC_EN && irq && (mtvec[1:0] == MTVEC_MODE_VEC)) begin
         base = base + (PC_W'(code) << 2);
      end
      return base;
   endfunction

   always_comb begin
      state_nxt      = state;
      drain_cnt_nxt  = drain_cnt;
      drain_cnt_inc  = drain_cnt + 1'b1;
      cause_irq_nxt  = cause_irq;
      cause_code_nxt = cause_code;
      epc_nxt        = epc;
      target_nxt     = target;
      retire         = 1'b0;
      mret_strobe    = 1'b0;
      trap_strobe    = 1'b0;
      tmo_strobe     = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (bus.cmt_valid) begin
               if (irq_valid || bus.cmt_excp) begin
                  cause_irq_nxt  = irq_valid;
                  cause_code_nxt = irq_valid ? irq_code : bus.cmt_excp_code;
                  epc_nxt        = {bus.cmt_pc[PC_W-1:1], 1'b0};
                  state_nxt      = bus.lsu_busy ? ST_DRAIN : ST_TRAP;
               end else if (bus.cmt_mret) begin
                  mret_strobe = 1'b1;
                  retire      = 1'b1;
                  target_nxt  = bus.csr_mepc;
                  state_nxt   = ST_FLUSH;
               end else begin
                  retire = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            // drain_cnt holds the DRAIN cycles already spent; drain_cnt_inc includes this one.
            if (!bus.lsu_busy) begin
               drain_cnt_nxt = '0;
               state_nxt     = ST_TRAP;
            end else if (drain_cnt_inc == TMO_LIMIT) begin
               tmo_strobe    = 1'b1;
               drain_cnt_nxt = '0;
               state_nxt     = ST_TRAP;
            end else begin
               drain_cnt_nxt = drain_cnt_inc;
            end
         end
         ST_TRAP: begin
            trap_strobe = 1'b1;
            target_nxt  = trap_target(bus.csr_mtvec, cause_irq, cause_code);
            state_nxt   = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (bus.flush_ack) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: all state, including the latched cause/epc/target, is reset so an aborted trap leaves nothing stale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         drain_cnt  <= '0;
         cause_irq  <= 1'b0;
         cause_code <= '0;
         epc        <= '0;
         target     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state      <= state_nxt;
         drain_cnt  <= drain_cnt_nxt;
         cause_irq  <= cause_irq_nxt;
         cause_code <= cause_code_nxt;
         epc        <= epc_nxt;
         target     <= target_nxt;
      end
   end

   assign bus.cmt_stall  = (state != ST_IDLE);
   assign bus.cmt_retire = retire;
   assign bus.mret_ena   = mret_strobe;
   assign bus.int_ena    = trap_strobe;
   assign bus.drain_tmo  = tmo_strobe;
   assign bus.i_mcause   = {cause_irq, {(PC_W-5){1'b0}}, cause_code};
   assign bus.epc_pc     = epc;
   assign bus.flush_req  = (state == ST_FLUSH);
   assign bus.flush_pc   = target;

   assign unused_bits = ^{bus.cmt_pc[0], bus.csr_mie[PC_W-1:12], bus.csr_mie[10:8],
                          bus.csr_mie[6:4], bus.csr_mie[2:0]};

endmodule

// File: tb/tb_exu_trap_ctrl.sv
// Self-checking bench for exu_trap_ctrl: directed literal sequences plus
// randomized commits checked every cycle against a transaction-level model.
module tb_exu_trap_ctrl;

   localparam int DRAIN_TMO = 255;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   bit   check_en;

   logic        e_stall, e_retire, e_int, e_mret, e_freq, e_tmo;
   logic [31:0] e_cause, e_epc, e_fpc;

   exu_trap_ctrl_if #(.PC_W(32)) bus ();

   exu_trap_ctrl #(.PC_W(32), .DRAIN_TMO(DRAIN_TMO), .TMO_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Single compare process: checks the current cycle's expectations away from the clock edge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (check_en) begin
            check("cmt_stall", bus.cmt_stall, e_stall);
            check("cmt_retire", bus.cmt_retire, e_retire);
            check("int_ena", bus.int_ena, e_int);
            check("mret_ena", bus.mret_ena, e_mret);
            check("flush_req", bus.flush_req, e_freq);
            check("drain_tmo", bus.drain_tmo, e_tmo);
            if (e_int) begin
               check("i_mcause", bus.i_mcause, e_cause);
               check("epc_pc", bus.epc_pc, e_epc);
            end
            if (e_freq) check("flush_pc", bus.flush_pc, e_fpc);
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- model ----------------
   function automatic void irq_model(output bit v, output logic [3:0] code);
      v    = 1'b1;
      code = 4'd0;
      if (!bus.csr_mstatus_mie)             v = 1'b0;
      else if (bus.ext_ip && bus.csr_mie[11]) code = 4'd11;
      else if (bus.sft_ip && bus.csr_mie[3])  code = 4'd3;
      else if (bus.tmr_ip && bus.csr_mie[7])  code = 4'd7;
      else                                    v = 1'b0;
   endfunction

   function automatic logic [31:0] model_target(input logic [31:0] mtvec, input bit irq,
                                                input logic [3:0] code);
      logic [31:0] t;
      t = mtvec & 32'hFFFF_FFFC;
`ifdef EXU_TRAP_VECTORED_EN
      if (irq && mtvec[1:0] == 2'b01) t = t + 32'(code) * 32'd4;
`endif
      return t;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic clr_exp(input logic stall);
      e_stall  = stall;
      e_retire = 1'b0;
      e_int    = 1'b0;
      e_mret   = 1'b0;
      e_freq   = 1'b0;
      e_tmo    = 1'b0;
      e_cause  = '0;
      e_epc    = '0;
      e_fpc    = '0;
   endtask

   // Randomizes every input that must be ignored outside IDLE (mtvec/mepc held).
   task automatic noise();
      bus.cmt_valid       = 1'($urandom);
      bus.cmt_pc          = $urandom;
      bus.cmt_excp        = 1'($urandom);
      bus.cmt_excp_code   = 4'($urandom);
      bus.cmt_mret        = 1'($urandom);
      bus.ext_ip          = 1'($urandom);
      bus.tmr_ip          = 1'($urandom);
      bus.sft_ip          = 1'($urandom);
      bus.csr_mie         = $urandom;
      bus.csr_mstatus_mie = 1'($urandom);
      bus.lsu_busy        = 1'($urandom);
      bus.flush_ack       = 1'($urandom);
   endtask

   task automatic quiet();
      bus.cmt_valid = 0; bus.cmt_pc = 0; bus.cmt_excp = 0; bus.cmt_excp_code = 0;
      bus.cmt_mret = 0; bus.ext_ip = 0; bus.tmr_ip = 0; bus.sft_ip = 0;
      bus.csr_mie = 0; bus.csr_mstatus_mie = 0; bus.csr_mtvec = 0; bus.csr_mepc = 0;
      bus.lsu_busy = 0; bus.flush_ack = 0;
   endtask

   task automatic flush_seq(input logic [31:0] tgt, input int ack_delay);
      for (int k = 0; k <= ack_delay; k++) begin
         next_cycle();
         noise();
         bus.flush_ack = (k == ack_delay);
         clr_exp(1'b1);
         e_freq = 1'b1;
         e_fpc  = tgt;
      end
   endtask

   // Cycles after a trapping commit: lsu_busy stays high for busy_len cycles counting the commit cycle.
   task automatic trap_seq(input logic [31:0] x_cause, input logic [31:0] x_epc,
                           input logic [31:0] x_tgt, input int busy_len, input int ack_delay);
      int n;
      n = (busy_len > DRAIN_TMO) ? DRAIN_TMO : busy_len;
      for (int j = 1; j <= n; j++) begin
         next_cycle();
         noise();
         bus.lsu_busy = (j < busy_len);
         clr_exp(1'b1);
         e_tmo = (j == DRAIN_TMO) && (busy_len > DRAIN_TMO);
      end
      next_cycle();
      noise();
      clr_exp(1'b1);
      e_int   = 1'b1;
      e_cause = x_cause;
      e_epc   = x_epc;
      flush_seq(x_tgt, ack_delay);
   endtask

   task automatic idle_check();
      next_cycle();
      quiet();
      clr_exp(1'b0);
   endtask

   task automatic random_txn();
      bit          iv;
      logic [3:0]  ic;
      int          busy_len;
      logic [31:0] epc;
      next_cycle();
      noise();
      bus.cmt_valid = ($urandom_range(0, 3) != 0);
      bus.cmt_excp  = ($urandom_range(0, 3) == 0);
      bus.cmt_mret  = ($urandom_range(0, 2) == 0);
      bus.csr_mtvec = $urandom;
      if ($urandom_range(0, 1) == 1) bus.csr_mtvec[1:0] = 2'b01;
      bus.csr_mepc  = $urandom;
      busy_len      = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
      bus.lsu_busy  = (busy_len > 0);
      irq_model(iv, ic);
      epc = bus.cmt_pc & 32'hFFFF_FFFE;
      clr_exp(1'b0);
      if (!bus.cmt_valid) return;
      if (iv) begin
         trap_seq({1'b1, 27'b0, ic}, epc, model_target(bus.csr_mtvec, 1'b1, ic),
                  busy_len, $urandom_range(0, 3));
      end else if (bus.cmt_excp) begin
         trap_seq({28'b0, bus.cmt_excp_code}, epc,
                  model_target(bus.csr_mtvec, 1'b0, bus.cmt_excp_code),
                  busy_len, $urandom_range(0, 3));
      end else if (bus.cmt_mret) begin
         e_mret   = 1'b1;
         e_retire = 1'b1;
         flush_seq(bus.csr_mepc, $urandom_range(0, 3));
      end else begin
         e_retire = 1'b1;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      vectors     = 0;
      miscompares = 0;
      check_en    = 1'b0;
      clr_exp(1'b0);
      quiet();
      rst_n = 1'b0;
      #2;
      check("reset cmt_stall", bus.cmt_stall, 0);
      check("reset cmt_retire", bus.cmt_retire, 0);
      check("reset int_ena", bus.int_ena, 0);
      check("reset mret_ena", bus.mret_ena, 0);
      check("reset flush_req", bus.flush_req, 0);
      check("reset flush_pc", bus.flush_pc, 0);
      check("reset i_mcause", bus.i_mcause, 0);
      check("reset epc_pc", bus.epc_pc, 0);
      check("reset drain_tmo", bus.drain_tmo, 0);
      next_cycle();
      rst_n    = 1'b1;
      check_en = 1'b1;

      // Plain instruction retires without stall or strobes.
      next_cycle();
      quiet();
      bus.cmt_valid = 1'b1;
      bus.cmt_pc    = 32'h40;
      clr_exp(1'b0);
      e_retire = 1'b1;

      // Exception code 2 at 0x100, no drain, mtvec 0x800, ack one cycle late.
      next_cycle();
      quiet();
      bus.cmt_valid     = 1'b1;
      bus.cmt_excp      = 1'b1;
      bus.cmt_excp_code = 4'd2;
      bus.cmt_pc        = 32'h100;
      bus.csr_mtvec     = 32'h800;
      clr_exp(1'b0);
      trap_seq(32'h2, 32'h100, 32'h800, 0, 1);
      idle_check();

      // MEI + MTI pending, MEI wins; five DRAIN cycles; mtvec 0x801.
      next_cycle();
      quiet();
      bus.cmt_valid       = 1'b1;
      bus.cmt_excp        = 1'b1;
      bus.cmt_pc          = 32'h305;
      bus.ext_ip          = 1'b1;
      bus.tmr_ip          = 1'b1;
      bus.csr_mie         = 32'h880;
      bus.csr_mstatus_mie = 1'b1;
      bus.csr_mtvec       = 32'h801;
      bus.lsu_busy        = 1'b1;
      clr_exp(1'b0);
`ifdef EXU_TRAP_VECTORED_EN
      trap_seq(32'h8000_000B, 32'h304, 32'h82C, 5, 0);
`else
      trap_seq(32'h8000_000B, 32'h304, 32'h800, 5, 0);
`endif
      idle_check();

      // LSU stuck busy: forced trap after 255 DRAIN cycles.
      next_cycle();
      quiet();
      bus.cmt_valid     = 1'b1;
      bus.cmt_excp      = 1'b1;
      bus.cmt_excp_code = 4'd5;
      bus.cmt_pc        = 32'h1000;
      bus.csr_mtvec     = 32'h900;
      bus.lsu_busy      = 1'b1;
      clr_exp(1'b0);
      trap_seq(32'h5, 32'h1000, 32'h900, 100000, 0);
      idle_check();

      // mret to 0x2000, ack after 3 waiting cycles.
      next_cycle();
      quiet();
      bus.cmt_valid = 1'b1;
      bus.cmt_mret  = 1'b1;
      bus.csr_mepc  = 32'h2000;
      clr_exp(1'b0);
      e_mret   = 1'b1;
      e_retire = 1'b1;
      flush_seq(32'h2000, 3);
      idle_check();

      // Asynchronous reset while waiting in FLUSH.
      next_cycle();
      quiet();
      bus.cmt_valid = 1'b1;
      bus.cmt_mret  = 1'b1;
      bus.csr_mepc  = 32'h3000;
      clr_exp(1'b0);
      e_mret   = 1'b1;
      e_retire = 1'b1;
      next_cycle();
      quiet();
      clr_exp(1'b1);
      e_freq = 1'b1;
      e_fpc  = 32'h3000;
      #4;
      check_en = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("async rst flush_req", bus.flush_req, 0);
      check("async rst cmt_stall", bus.cmt_stall, 0);
      check("async rst flush_pc", bus.flush_pc, 0);
      next_cycle();
      rst_n = 1'b1;
      clr_exp(1'b0);
      check_en = 1'b1;

      for (int t = 0; t < 400; t++) random_txn();
      idle_check();
      next_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
